// File: rtl/mux_n_1_arb_if.sv
// Bundle of the N-channel producer side and single consumer side of mux_n_1_arb.
// Latency: none (wires only).
// Backpressure: carries in_ready/out_ready; the mux drives in_ready, the consumer drives out_ready.
interface mux_n_1_arb_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
);
  logic              mode;
  logic [SELW-1:0]   sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [WIDTH-1:0]  out_data;
  logic [SELW-1:0]   out_chan;
  logic              out_valid;
  logic              out_ready;

  // Environment side: producers, consumer and mode/select control.
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  // Mux side.
  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_n_1_arb.sv
// N:1 mux with fixed-select or round-robin grant into a single registered output beat tagged with its source.
// Latency: 1 cycle from input transfer to out_valid; 1 beat/cycle sustained with out_ready=1.
// Backpressure: a held beat (out_valid && !out_ready) drops every in_ready and freezes output and rr pointer.
module mux_n_1_arb #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input logic          clk,
  input logic          rst_n,
  mux_n_1_arb_if.slave bus
);

  // Valid vector padded up to the full select range so that sel >= N reads a 0 and never grants.
  localparam int NPAD = 1 << SELW;

  localparam logic [SELW:0]   N_EXT = (SELW + 1)'(N);
  localparam logic [SELW-1:0] LAST  = SELW'(N - 1);

  logic [WIDTH-1:0] ch_data [N];
  logic [NPAD-1:0]  valid_pad;
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic [SELW:0]    rr_idx;
  logic             load;
  logic [N-1:0]     in_ready_w;

  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_chan_q;
  logic             out_valid_q;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign ch_data[k] = bus.in_data[k*WIDTH +: WIDTH];
  end

  assign valid_pad = NPAD'(bus.in_valid);

  // The output register can take a new beat when it is empty or being drained this cycle.
  assign load = !out_valid_q || bus.out_ready;

  // Grant selection: direct select in fixed mode, first valid channel from rr_ptr upward (wrapping) otherwise.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    rr_idx    = '0;
    if (!bus.mode) begin
      if (valid_pad[bus.sel]) begin
        grant     = bus.sel;
        grant_vld = 1'b1;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        rr_idx = {1'b0, rr_ptr} + (SELW + 1)'(i);
        if (rr_idx >= N_EXT) begin
          rr_idx = rr_idx - N_EXT;
        end
        if (!grant_vld && valid_pad[rr_idx[SELW-1:0]]) begin
          grant     = rr_idx[SELW-1:0];
          grant_vld = 1'b1;
        end
      end
    end
  end

  // One-hot ready to the granted channel only; held low throughout reset.
  always_comb begin
    in_ready_w = '0;
    if (rst_n && load && grant_vld) begin
      in_ready_w[grant] = 1'b1;
    end
  end

  // Output beat register and round-robin pointer; a load with no grant empties the register but keeps data/chan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr      <= '0;
    end else if (load) begin
      if (grant_vld) begin
        out_data_q  <= ch_data[grant];
        out_chan_q  <= grant;
        out_valid_q <= 1'b1;
        rr_ptr      <= (grant == LAST) ? '0 : grant + 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;

endmodule
